// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory access controller.
package imem_pkg;

  localparam int          DEPTH      = 64;
  localparam int          AW         = 6;
  localparam int          STARVE_MAX = 8;
  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [15:0] NOP_WORD   = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
  } state_e;

  // True when a 16-bit PC lands inside the populated memory.
  function automatic logic addr_in_range(input logic [15:0] a);
    return a < 16'(DEPTH);
  endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating counter with synchronous clear, used to bound loader starvation.
module imem_starve_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  // Count denied cycles, hold at MAX, clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (inc && cnt != W'(MAX))      cnt <= cnt + 1'b1;
  end

  assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single instruction memory between IF fetches and the program
// loader. Fetch is held stalled until the boot image is written; afterwards
// fetch has priority, with the loader forced through after a bounded wait.
module imem_access_ctrl
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          fetch_req,
  input  logic [15:0]   fetch_addr,
  output logic [15:0]   fetch_inst,
  output logic          fetch_stall,
  output logic          fetch_fault,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data,
  input  logic          ld_last,
  output logic          boot_done,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_we,
  input  logic [15:0]   mem_rdata
);

  state_e state;
  logic   in_run;
  logic   ld_grant;
  logic   ld_ready_c;
  logic   fetch_grant;
  logic   fetch_ok;
  logic   starve_sat;
  logic   starve_inc;

  assign in_run = (state == RUN);

  // Grant decision: loader owns the port throughout boot; in run it gets the
  // port when fetch is idle or once it has waited long enough.
  always_comb begin
    ld_grant   = 1'b0;
    ld_ready_c = 1'b0;
    case (state)
      BOOT: begin
        ld_grant   = ld_valid;
        ld_ready_c = 1'b1;
      end
      RUN: begin
        ld_grant   = ld_valid & (~fetch_req | starve_sat);
        ld_ready_c = ld_grant;
      end
      default: begin
        ld_grant   = 1'b0;
        ld_ready_c = 1'b0;
      end
    endcase
  end

  assign fetch_grant = in_run & fetch_req & ~ld_grant;
  assign fetch_ok    = fetch_grant & addr_in_range(fetch_addr);

  // Output muxing; everything is gated by reset so an in-flight write is
  // dropped the moment reset asserts, independent of the clock.
  always_comb begin
    fetch_stall = 1'b1;
    fetch_fault = 1'b0;
    fetch_inst  = NOP_WORD;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    if (reset_n) begin
      // Stall only matters while IF is actually asking for an instruction.
      fetch_stall = ~in_run | (fetch_req & ld_grant);
      fetch_fault = fetch_grant & ~addr_in_range(fetch_addr);
      fetch_inst  = fetch_ok ? mem_rdata : NOP_WORD;
      ld_ready    = ld_ready_c;
      mem_we      = ld_grant;
      if (ld_grant)      mem_addr = ld_addr;
      else if (fetch_ok) mem_addr = fetch_addr[AW-1:0];
    end
  end

  assign mem_wdata = ld_data;

  // A run-time loader request that loses arbitration accumulates wait credit;
  // any grant, an idle loader or boot mode resets it.
  assign starve_inc = in_run & ld_valid & ~ld_grant;

  imem_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (starve_inc),
    .clr     (~starve_inc),
    .sat     (starve_sat)
  );

  // Boot sequencing: leave BOOT on the last image word; run is terminal
  // until the next reset, so a stray ld_last later on is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      boot_done <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (ld_valid && ld_last) begin
            state     <= RUN;
            boot_done <= 1'b1;
          end
        end
        RUN: begin
          state     <= RUN;
          boot_done <= 1'b1;
        end
        default: begin
          state     <= BOOT;
          boot_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
